// File: rtl/answer_pkg.sv
// rtl/answer_pkg.sv - shared state encodings, player limits and saturating score helpers
package answer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ANSWER = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int SCORE_W = 8;
    localparam int N_MIN   = 2;
    localparam int N_MAX   = 4;

    // Scores up to 16 bits; the caller supplies the ceiling for its own width.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [5:0] p,
                                            input logic [15:0] maxv);
        logic [16:0] s;
        s = {1'b0, a} + {11'd0, p};
        sat_add = (s > {1'b0, maxv}) ? maxv : s[15:0];
    endfunction

    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [5:0] p);
        sat_sub = (a < {10'd0, p}) ? 16'd0 : a - {10'd0, p};
    endfunction

endpackage

// File: rtl/sec_tick.sv
// rtl/sec_tick.sv - one-second prescaler with synchronous clear and single-cycle tick
module sec_tick #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && !i_clr && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/answer_arbiter.sv
// rtl/answer_arbiter.sv - buzz arbitration, answer countdown and score keeping per round
// Optional macro EARLY_BUZZ_PENALTY_EN: buzzing in IDLE/DONE costs the latched mistake points.
module answer_arbiter #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int SCORE_W     = 8,
    parameter int N_MAX       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [5:0]           num_people,
    input  logic [5:0]           count_seconds,
    input  logic [5:0]           correct_point,
    input  logic [5:0]           mistake_point,
    input  logic                 start_btn,
    input  logic                 judge_ok,
    input  logic                 judge_bad,
    input  logic                 score_clr,
    input  logic [3:0]           buzz,
    output logic [1:0]           state,
    output logic                 winner_valid,
    output logic [1:0]           winner,
    output logic [5:0]           remaining,
    output logic                 timeout,
    output logic [4*SCORE_W-1:0] scores
);

    import answer_pkg::*;

    localparam logic [15:0] SCORE_MAX = 16'((32'd1 << SCORE_W) - 32'd1);

    state_t             r_state, w_next;
    logic [3:0]         r_buzz_d;
    logic [2:0]         r_n;
    logic [5:0]         r_t, r_c, r_m;
    logic [1:0]         r_ptr;
    logic               r_wv;
    logic [1:0]         r_winner;
    logic [5:0]         r_remaining;
    logic               r_timeout;
    logic [SCORE_W-1:0] r_score [4];

    logic [3:0] w_edge, w_req;
    logic       w_start, w_judge, w_tick, w_fire_timeout, w_in_answer;
    logic       w_grant;
    logic [1:0] w_gidx, w_ptr_next;
    logic [2:0] w_ptr_eff, w_slot, w_n_new;
    logic [5:0] w_t_new;

    assign w_start        = start_btn && cfg_valid;
    assign w_judge        = judge_ok || judge_bad;
    assign w_edge         = buzz & ~r_buzz_d;
    assign w_in_answer    = (r_state == ST_ANSWER);
    assign w_fire_timeout = w_tick && (r_remaining == 6'd1) && !w_judge;

    assign w_n_new = (num_people < 6'(N_MIN)) ? 3'(N_MIN) :
                     (num_people > 6'(N_MAX)) ? 3'(N_MAX) : num_people[2:0];
    assign w_t_new = (count_seconds == 6'd0) ? 6'd1 : count_seconds;

    sec_tick #(.TICK_CYCLES(TICK_CYCLES)) u_sec_tick (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!w_in_answer),
        .i_en   (w_in_answer),
        .o_tick (w_tick)
    );

    always_comb begin
        w_req = '0;
        for (int i = 0; i < 4; i++) begin
            w_req[i] = w_edge[i] && (3'(i) < r_n);
        end
    end

    // Rotating scan: descending loop so the lowest offset from ptr wins. A ptr left
    // over from a larger N is folded back into range first.
    always_comb begin
        w_grant   = 1'b0;
        w_gidx    = '0;
        w_ptr_eff = ({1'b0, r_ptr} >= r_n) ? {1'b0, r_ptr} - r_n : {1'b0, r_ptr};
        w_slot    = '0;
        for (int i = 3; i >= 0; i--) begin
            w_slot = w_ptr_eff + 3'(i);
            if (w_slot >= r_n) begin
                w_slot = w_slot - r_n;
            end
            if ((3'(i) < r_n) && w_req[w_slot[1:0]]) begin
                w_grant = 1'b1;
                w_gidx  = w_slot[1:0];
            end
        end
    end

    assign w_ptr_next = (({1'b0, w_gidx} + 3'd1) == r_n) ? 2'd0 : w_gidx + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_ARMED;
            ST_ARMED:  if (!cfg_valid) w_next = ST_IDLE;
                       else if (w_grant) w_next = ST_ANSWER;
            ST_ANSWER: if (!cfg_valid) w_next = ST_IDLE;
                       else if (w_judge || w_fire_timeout) w_next = ST_DONE;
            ST_DONE:   if (!cfg_valid) w_next = ST_IDLE;
                       else if (w_start) w_next = ST_ARMED;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buzz_d    <= '0;
            r_n         <= 3'(N_MIN);
            r_t         <= '0;
            r_c         <= '0;
            r_m         <= '0;
            r_ptr       <= '0;
            r_wv        <= 1'b0;
            r_winner    <= '0;
            r_remaining <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_buzz_d  <= buzz;
            r_timeout <= 1'b0;
            if ((r_state != ST_IDLE) && !cfg_valid) begin
                r_wv        <= 1'b0;
                r_remaining <= '0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_start) begin
                            r_n  <= w_n_new;
                            r_t  <= w_t_new;
                            r_c  <= correct_point;
                            r_m  <= mistake_point;
                            r_wv <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (w_grant) begin
                            r_wv        <= 1'b1;
                            r_winner    <= w_gidx;
                            r_remaining <= r_t;
                            r_ptr       <= w_ptr_next;
                        end
                    end
                    ST_ANSWER: begin
                        if (!w_judge && w_tick) begin
                            r_remaining <= r_remaining - 6'd1;
                            r_timeout   <= (r_remaining == 6'd1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_score[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_in_answer && cfg_valid && (2'(k) == r_winner)) begin
                    if (judge_ok) begin
                        r_score[k] <= SCORE_W'(sat_add(16'(r_score[k]), r_c, SCORE_MAX));
                    end else if (judge_bad || w_fire_timeout) begin
                        r_score[k] <= SCORE_W'(sat_sub(16'(r_score[k]), r_m));
                    end
                end else if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
                    if (score_clr) begin
                        r_score[k] <= '0;
                    end
`ifdef EARLY_BUZZ_PENALTY_EN
                    else if (cfg_valid && w_req[k]) begin
                        r_score[k] <= SCORE_W'(sat_sub(16'(r_score[k]), r_m));
                    end
`endif
                end
            end
        end
    end

    assign state        = r_state;
    assign winner_valid = r_wv;
    assign winner       = r_winner;
    assign remaining    = r_remaining;
    assign timeout      = r_timeout;

    for (genvar g = 0; g < 4; g++) begin : g_scores
        assign scores[g*SCORE_W +: SCORE_W] = r_score[g];
    end

endmodule

// File: tb/tb_answer_arbiter.sv
// tb/tb_answer_arbiter.sv - directed and randomized checks of answer_arbiter against a round-level model
module tb_answer_arbiter;

    localparam int TC = 10;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [5:0]    num_people = '0, count_seconds = '0, correct_point = '0, mistake_point = '0;
    logic          start_btn = 1'b0, judge_ok = 1'b0, judge_bad = 1'b0, score_clr = 1'b0;
    logic [3:0]    buzz = '0;
    logic [1:0]    state;
    logic          winner_valid;
    logic [1:0]    winner;
    logic [5:0]    remaining;
    logic          timeout;
    logic [4*SW-1:0] scores;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state, m_wv, m_winner, m_rem, m_to, m_ptr, m_n, m_t, m_c, m_m, m_age;
    int m_sc [4];
    logic [3:0] m_prev;

    answer_arbiter #(.TICK_CYCLES(TC), .SCORE_W(SW), .N_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .num_people    (num_people),
        .count_seconds (count_seconds),
        .correct_point (correct_point),
        .mistake_point (mistake_point),
        .start_btn     (start_btn),
        .judge_ok      (judge_ok),
        .judge_bad     (judge_bad),
        .score_clr     (score_clr),
        .buzz          (buzz),
        .state         (state),
        .winner_valid  (winner_valid),
        .winner        (winner),
        .remaining     (remaining),
        .timeout       (timeout),
        .scores        (scores)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int score_of(input int k);
        return int'(scores[k*SW +: SW]);
    endfunction

    task automatic model_reset();
        m_state = 0; m_wv = 0; m_winner = 0; m_rem = 0; m_to = 0; m_ptr = 0;
        m_n = 2; m_t = 0; m_c = 0; m_m = 0; m_age = 0; m_prev = '0;
        for (int k = 0; k < 4; k++) m_sc[k] = 0;
    endtask

    task automatic leave_round();
        m_state = 0; m_wv = 0; m_rem = 0;
    endtask

    function automatic int lose(input int s, input int p);
        return (s > p) ? s - p : 0;
    endfunction

    task automatic model_step();
        logic [3:0] e;
        int idx;
        bit found;
        if (rst) begin
            model_reset();
            return;
        end
        e = buzz & ~m_prev;
        m_prev = buzz;
        m_to = 0;
        case (m_state)
            0, 3: begin
                if (score_clr) begin
                    for (int k = 0; k < 4; k++) m_sc[k] = 0;
                end
`ifdef EARLY_BUZZ_PENALTY_EN
                else if (cfg_valid) begin
                    for (int k = 0; k < m_n; k++) if (e[k]) m_sc[k] = lose(m_sc[k], m_m);
                end
`endif
                if (!cfg_valid) begin
                    leave_round();
                end else if (start_btn) begin
                    m_n = (num_people < 2) ? 2 : (num_people > 4) ? 4 : int'(num_people);
                    m_t = (count_seconds == 0) ? 1 : int'(count_seconds);
                    m_c = int'(correct_point);
                    m_m = int'(mistake_point);
                    m_state = 1;
                    m_wv = 0;
                end
            end
            1: begin
                if (!cfg_valid) begin
                    leave_round();
                end else begin
                    found = 0;
                    for (int i = 0; i < m_n; i++) begin
                        idx = (m_ptr + i) % m_n;
                        if (!found && e[idx]) begin
                            found = 1;
                            m_winner = idx;
                            m_wv = 1;
                            m_rem = m_t;
                            m_state = 2;
                            m_ptr = (idx + 1) % m_n;
                            m_age = 0;
                        end
                    end
                end
            end
            default: begin
                if (!cfg_valid) begin
                    leave_round();
                end else begin
                    m_age++;
                    if (judge_ok) begin
                        m_sc[m_winner] = (m_sc[m_winner] + m_c > 255) ? 255 : m_sc[m_winner] + m_c;
                        m_state = 3;
                    end else if (judge_bad) begin
                        m_sc[m_winner] = lose(m_sc[m_winner], m_m);
                        m_state = 3;
                    end else if (m_age % TC == 0) begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_to = 1;
                            m_sc[m_winner] = lose(m_sc[m_winner], m_m);
                            m_state = 3;
                        end
                    end
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst) model_reset();
        chk("state", int'(state), m_state);
        chk("winner_valid", int'(winner_valid), m_wv);
        chk("winner", int'(winner), m_winner);
        chk("remaining", int'(remaining), m_rem);
        chk("timeout", int'(timeout), m_to);
        for (int k = 0; k < 4; k++) chk($sformatf("score%0d", k), score_of(k), m_sc[k]);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start_btn = 1'b1; step(); start_btn = 1'b0;
    endtask

    task automatic buzz_pulse(input logic [3:0] v);
        buzz = v; step(); buzz = '0;
    endtask

    task automatic judge(input logic ok, input logic bad);
        judge_ok = ok; judge_bad = bad; step(); judge_ok = 1'b0; judge_bad = 1'b0;
    endtask

    initial begin
        cfg_valid = 1'b1; num_people = 6'd3; count_seconds = 6'd5;
        correct_point = 6'd2; mistake_point = 6'd1;
        step();
        chk("rst_state", int'(state), 0);
        chk("rst_wv", int'(winner_valid), 0);
        chk("rst_rem", int'(remaining), 0);
        chk("rst_scores", int'(scores), 0);
        rst = 1'b0;
        step();

        pulse_start();
        chk("s1_armed", int'(state), 1);
        buzz_pulse(4'b0010);
        chk("s1_wv", int'(winner_valid), 1);
        chk("s1_winner", int'(winner), 1);
        chk("s1_rem", int'(remaining), 5);
        judge(1'b1, 1'b0);
        chk("s1_score1", score_of(1), 2);
        chk("s1_done", int'(state), 3);

        pulse_start(); buzz_pulse(4'b0001);
        chk("s2_winner0", int'(winner), 0);
        judge(1'b0, 1'b1);
        chk("s2_sat0", score_of(0), 0);
        pulse_start(); buzz_pulse(4'b0011);
        chk("s2_ptr1", int'(winner), 1);
        judge(1'b1, 1'b0);
        pulse_start(); buzz_pulse(4'b0011);
        chk("s2_wrap", int'(winner), 0);
        judge(1'b1, 1'b0);
        chk("s2_score0", score_of(0), 2);

        count_seconds = 6'd2;
        pulse_start(); buzz_pulse(4'b0100);
        chk("s3_winner", int'(winner), 2);
        repeat (9) step();
        chk("s3_rem2", int'(remaining), 2);
        step();
        chk("s3_rem1", int'(remaining), 1);
        repeat (9) step();
        chk("s3_rem1b", int'(remaining), 1);
        step();
        chk("s3_rem0", int'(remaining), 0);
        chk("s3_timeout", int'(timeout), 1);
        chk("s3_score2", score_of(2), 0);
        step();
        chk("s3_pulse", int'(timeout), 0);

        num_people = 6'd2;
        pulse_start(); buzz_pulse(4'b1100);
        chk("s4_nogrant", int'(state), 1);
        buzz_pulse(4'b0001);
        chk("s4_winner", int'(winner), 0);
        judge(1'b0, 1'b1);
        chk("s4_score0", score_of(0), 1);

        num_people = 6'd3; count_seconds = 6'd1; correct_point = 6'd5;
        pulse_start(); buzz_pulse(4'b0010);
        chk("s5_winner", int'(winner), 1);
        repeat (9) step();
        judge(1'b1, 1'b1);
        chk("s5_score1", score_of(1), 9);
        chk("s5_no_to", int'(timeout), 0);
        pulse_start(); buzz_pulse(4'b0100);
        cfg_valid = 1'b0; step(); cfg_valid = 1'b1;
        chk("s5_idle", int'(state), 0);
        chk("s5_keep1", score_of(1), 9);

        correct_point = 6'd3; mistake_point = 6'd2;
        pulse_start(); buzz_pulse(4'b0100);
        judge(1'b1, 1'b0);
        chk("s6_score2", score_of(2), 3);
        buzz_pulse(4'b0100); step();
`ifdef EARLY_BUZZ_PENALTY_EN
        chk("s6_early1", score_of(2), 1);
        buzz_pulse(4'b0100); step();
        chk("s6_early0", score_of(2), 0);
        buzz_pulse(4'b0100); step();
        chk("s6_early_sat", score_of(2), 0);
`else
        chk("s6_ignored", score_of(2), 3);
`endif

        pulse_start(); buzz_pulse(4'b0001);
        rst = 1'b1; #1;
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_scores", int'(scores), 0);
        step(); rst = 1'b0; step();

        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 499) == 0);
            cfg_valid = ($urandom_range(0, 49) != 0);
            start_btn = ($urandom_range(0, 19) == 0);
            judge_ok  = ($urandom_range(0, 29) == 0);
            judge_bad = ($urandom_range(0, 29) == 0);
            score_clr = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) buzz[b] = ~buzz[b];
            if ($urandom_range(0, 31) == 0) begin
                num_people    = 6'($urandom_range(0, 7));
                count_seconds = 6'($urandom_range(0, 3));
                correct_point = 6'($urandom_range(0, 63));
                mistake_point = 6'($urandom_range(0, 63));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
